squeeze_serializer: RTL and testbench
=====================================

SQUEEZE_SERIALIZER -- requirements
Module: squeeze_serializer

Interface
REQ-001 SHALL have parameter RATE, default 1088, rate in bits per squeezed block (SHAKE256).
REQ-002 SHALL have parameter LEN_W, default 16, width of the requested output length.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a squeeze of out_len bits.
REQ-006 SHALL have port out_len  input  LEN_W  number of output bits requested, sampled with start.
REQ-007 SHALL have port block_in  input  RATE  rate portion of the sponge state.
REQ-008 SHALL have port block_valid  input  1  block_in holds a fresh post-permutation block.
REQ-009 SHALL have port block_ready  output  1  requests and accepts the next block.
REQ-010 SHALL have port serial_out  output  1  current output bit.
REQ-011 SHALL have port serial_valid  output  1  serial_out is valid.
REQ-012 SHALL have port serial_ready  input  1  downstream accepts serial_out.
REQ-013 SHALL have port serial_last  output  1  marks the final requested bit.
REQ-014 SHALL have port squeeze_done  output  1  all requested bits transferred.
REQ-015 SHALL have port error_flag  output  1  illegal request (out_len==0).
REQ-016 SHALL have ports debug_state  output  3 and debug_bitcount  output  11, both continuously reflecting the FSM state and the in-block bit index.

Function
REQ-017 FSM states SHALL be IDLE=0, WAIT_BLOCK=1, SHIFT=2, DONE=3.
REQ-018 IDLE or DONE, start=1: latch out_len into remaining; clear squeeze_done and error_flag; go WAIT_BLOCK; if out_len==0, instead set error_flag=1 and go DONE.
REQ-019 start SHALL be ignored in WAIT_BLOCK and SHIFT.
REQ-020 WAIT_BLOCK: block_ready=1; when block_valid=1, load block_in into the internal buffer, set bit index to 0 and go SHIFT on the next edge.
REQ-021 block_ready SHALL be 0 in every state except WAIT_BLOCK.
REQ-022 SHIFT: serial_valid=1 and serial_out=buffer bit at the current index, LSB first (bit 0 first), matching the absorb-side bit order.
REQ-023 A transfer SHALL occur when serial_valid and serial_ready are both 1; only then SHALL the index increment and remaining decrement.
REQ-024 serial_out and serial_last SHALL hold stable while serial_valid=1 and serial_ready=0.
REQ-025 serial_last SHALL be 1 exactly when in SHIFT and remaining==1.
REQ-026 On a transfer with remaining==1: go DONE, taking priority over the block boundary.
REQ-027 On a transfer at index RATE-1 with remaining>1: go WAIT_BLOCK for the next block.
REQ-028 DONE: squeeze_done=1, serial_valid=0; remain until start.
REQ-029 Latency: start at cycle 0 gives block_ready=1 at cycle 1; block accepted at cycle k gives serial_valid=1 at cycle k+1.
REQ-030 Each block boundary SHALL insert at least one serial_valid=0 cycle.
REQ-031 debug_bitcount SHALL hold the in-block index (0..RATE-1).

Reset
REQ-032 While reset is high, the block SHALL reset asynchronously: state=IDLE, buffer=0, index=0, remaining=0.
REQ-033 While reset is high, all outputs SHALL be 0.
REQ-034 Reset mid-operation SHALL abandon the squeeze without emitting further bits.

Structure
REQ-035 RATE, the state encodings and the debug widths SHALL live in shared package keccak_pkg.
REQ-036 The RATE-bit buffer with index select SHALL be a sub-module, squeeze_shift_buffer; the FSM and counters SHALL stay in squeeze_serializer.

Verification
REQ-037 out_len=8 with block_in[7:0]=8'hA5 and serial_ready=1 SHALL produce bits 1,0,1,0,0,1,0,1 on consecutive cycles, serial_last on the 8th bit, then squeeze_done=1.
REQ-038 out_len=RATE+4 SHALL produce 1088 bits, then block_ready=1 again; the second block's bits 0..3 SHALL follow, with serial_last on the 1092nd bit.
REQ-039 Holding serial_ready=0 for 5 cycles mid-stream SHALL keep serial_out and serial_last stable, leave the index unchanged and drop no bits.
REQ-040 start with out_len=0 SHALL give error_flag=1, squeeze_done=1 and no serial_valid; a following start with out_len=4 SHALL clear error_flag and proceed.
REQ-041 start pulsed during SHIFT SHALL be ignored; reset asserted mid-SHIFT SHALL force serial_valid=0 and state=IDLE immediately.

Source files
------------

// File: rtl/squeeze_serializer_pkg.sv
// Shared Keccak squeeze definitions: rate, FSM encoding and debug widths.
package keccak_pkg;

  localparam int SHAKE256_RATE = 1088;
  localparam int DBG_STATE_W   = 3;
  localparam int DBG_IDX_W     = 11;

  typedef enum logic [DBG_STATE_W-1:0] {
    IDLE       = 3'd0,
    WAIT_BLOCK = 3'd1,
    SHIFT      = 3'd2,
    DONE       = 3'd3
  } sq_state_e;

endpackage

// File: rtl/squeeze_serializer_if.sv
// Block-in and serial-out handshakes of the squeeze serializer.
// master = the serializer, slave = the sponge core / downstream consumer.
interface squeeze_serializer_if #(
  parameter int RATE = keccak_pkg::SHAKE256_RATE
);
  logic [RATE-1:0] block_in;
  logic            block_valid;
  logic            block_ready;
  logic            serial_out;
  logic            serial_valid;
  logic            serial_ready;
  logic            serial_last;

  modport master (
    input  block_in, block_valid, serial_ready,
    output block_ready, serial_out, serial_valid, serial_last
  );

  modport slave (
    output block_in, block_valid, serial_ready,
    input  block_ready, serial_out, serial_valid, serial_last
  );
endinterface

// File: rtl/squeeze_serializer_shift_buffer.sv
// Holds one rate-sized squeezed block and selects the bit at the given index.
module squeeze_shift_buffer
  import keccak_pkg::*;
#(
  parameter int RATE  = SHAKE256_RATE,
  parameter int IDX_W = DBG_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [RATE-1:0]  data_in,
  input  logic [IDX_W-1:0] index,
  output logic             bit_out
);

  logic [RATE-1:0] buf_q;

  // Capture a fresh block when the FSM accepts one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) buf_q <= '0;
    else if (load) buf_q <= data_in;
  end

  // LSB-first bit select; an out-of-range index reads as 0.
  always_comb begin
    bit_out = 1'b0;
    if (index < IDX_W'(RATE)) bit_out = buf_q[index];
  end

endmodule

// File: rtl/squeeze_serializer.sv
// Squeeze-phase serializer: pulls rate blocks and streams out_len bits LSB first.
//
// state      | meaning
// IDLE       | waiting for start after reset
// WAIT_BLOCK | block_ready high, waiting for the next permuted block
// SHIFT      | presenting buffer bits on the serial handshake
// DONE       | request complete (or rejected), waiting for start
module squeeze_serializer
  import keccak_pkg::*;
#(
  parameter int RATE  = SHAKE256_RATE,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       out_len,
  squeeze_serializer_if.master   bus,
  output logic                   squeeze_done,
  output logic                   error_flag,
  output logic [DBG_STATE_W-1:0] debug_state,
  output logic [DBG_IDX_W-1:0]   debug_bitcount
);

  sq_state_e            state_q, state_d;
  logic [DBG_IDX_W-1:0] idx_q;
  logic [LEN_W-1:0]     rem_q;
  logic                 err_q;
  logic                 load;
  logic                 xfer;
  logic                 take_start;
  logic                 buf_bit;

  squeeze_shift_buffer #(
    .RATE  (RATE),
    .IDX_W (DBG_IDX_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (bus.block_in),
    .index   (idx_q),
    .bit_out (buf_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; last bit beats the block boundary.
  always_comb begin
    state_d          = state_q;
    load             = 1'b0;
    xfer             = 1'b0;
    take_start       = 1'b0;
    bus.block_ready  = 1'b0;
    bus.serial_valid = 1'b0;
    bus.serial_out   = 1'b0;
    bus.serial_last  = 1'b0;
    squeeze_done     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        squeeze_done = (state_q == DONE);
        if (start) begin
          take_start = 1'b1;
          state_d    = (out_len == '0) ? DONE : WAIT_BLOCK;
        end
      end
      WAIT_BLOCK: begin
        bus.block_ready = 1'b1;
        if (bus.block_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bus.serial_valid = 1'b1;
        bus.serial_out   = buf_bit;
        bus.serial_last  = (rem_q == LEN_W'(1));
        if (bus.serial_ready) begin
          xfer = 1'b1;
          if (rem_q == LEN_W'(1))                    state_d = DONE;
          else if (idx_q == DBG_IDX_W'(RATE - 1))    state_d = WAIT_BLOCK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit index, remaining-length counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (take_start) begin
        rem_q <= out_len;
        err_q <= (out_len == '0);
      end
      if (load) begin
        idx_q <= '0;
      end else if (xfer) begin
        rem_q <= rem_q - LEN_W'(1);
        if (idx_q != DBG_IDX_W'(RATE - 1)) idx_q <= idx_q + DBG_IDX_W'(1);
      end
    end
  end

  assign error_flag     = err_q;
  assign debug_state    = state_q;
  assign debug_bitcount = idx_q;

endmodule

// File: tb/tb_squeeze_serializer.sv
// Self-checking bench: random blocks and backpressure against a bit-stream model.
module tb_squeeze_serializer;

  localparam int RATE  = keccak_pkg::SHAKE256_RATE;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] out_len = '0;
  logic             squeeze_done, error_flag;
  logic [2:0]       debug_state;
  logic [10:0]      debug_bitcount;

  int checks = 0;
  int errors = 0;

  squeeze_serializer_if #(.RATE(RATE)) sif();

  squeeze_serializer #(.RATE(RATE), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .out_len        (out_len),
    .bus            (sif),
    .squeeze_done   (squeeze_done),
    .error_flag     (error_flag),
    .debug_state    (debug_state),
    .debug_bitcount (debug_bitcount)
  );

  always #5 clk = ~clk;

  function automatic logic [RATE-1:0] rand_block();
    logic [RATE-1:0] b;
    b = '0;
    for (int i = 0; i < RATE; i += 32) b[i +: 32] = $urandom();
    return b;
  endfunction

  task automatic test_reset();
    sif.block_in = '0; sif.block_valid = 1'b0; sif.serial_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sif.block_ready, sif.serial_out, sif.serial_valid, sif.serial_last,
         squeeze_done, error_flag, debug_state, debug_bitcount} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b out=%b vld=%b last=%b done=%b err=%b st=%0d idx=%0d, all required 0",
               sif.block_ready, sif.serial_out, sif.serial_valid, sif.serial_last,
               squeeze_done, error_flag, debug_state, debug_bitcount);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (debug_state !== 3'd0) begin
      errors++; $display("FAIL reset_idle: state %0d required 0", debug_state);
    end
  endtask

  task automatic test_a5();
    logic [RATE-1:0] blk;
    logic [7:0] pat;
    pat = 8'hA5;
    blk = rand_block();
    blk[7:0] = pat;
    start = 1'b1; out_len = LEN_W'(8);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (sif.block_ready !== 1'b1) begin
      errors++; $display("FAIL a5_latency: block_ready %b required 1", sif.block_ready);
    end
    sif.block_in = blk; sif.block_valid = 1'b1; sif.serial_ready = 1'b1;
    @(negedge clk);
    sif.block_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sif.serial_valid !== 1'b1 || sif.serial_out !== pat[i] || sif.serial_last !== (i == 7)) begin
        errors++;
        $display("FAIL a5_bit%0d: vld=%b out=%b last=%b required vld=1 out=%b last=%b",
                 i, sif.serial_valid, sif.serial_out, sif.serial_last, pat[i], (i == 7));
      end
      @(negedge clk);
    end
    checks++;
    if (squeeze_done !== 1'b1 || sif.serial_valid !== 1'b0 || debug_state !== 3'd3) begin
      errors++;
      $display("FAIL a5_done: done=%b vld=%b st=%0d required done=1 vld=0 st=3",
               squeeze_done, sif.serial_valid, debug_state);
    end
    sif.serial_ready = 1'b0;
  endtask

  // Model: the stream is the concatenation of accepted blocks, LSB first, truncated to len.
  task automatic run_squeeze(input string name, input int len, input int ready_pct,
                             input int block_pct, input int stall_at, input int start_at);
    bit              exp_q[$];
    int              rx, blocks, stall_left, budget;
    bit              stall_done, prev_stall, prev_boundary;
    logic            prev_out, prev_last;
    logic [10:0]     prev_idx;
    logic [RATE-1:0] blk;
    @(negedge clk);
    start = 1'b1; out_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (sif.block_ready !== 1'b1 || error_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: block_ready=%b err=%b required 1 and 0", name, sif.block_ready, error_flag);
    end
    rx = 0; blocks = 0; stall_left = 0; stall_done = 0; prev_stall = 0; prev_boundary = 0;
    prev_out = 0; prev_last = 0; prev_idx = '0;
    budget = len * 30 + 200;
    for (int cyc = 0; cyc < budget && rx < len; cyc++) begin
      if (prev_stall) begin
        checks++;
        if (sif.serial_valid !== 1'b1 || sif.serial_out !== prev_out ||
            sif.serial_last !== prev_last || debug_bitcount !== prev_idx) begin
          errors++;
          $display("FAIL %s_stall_hold: vld=%b out=%b last=%b idx=%0d required 1 %b %b %0d",
                   name, sif.serial_valid, sif.serial_out, sif.serial_last, debug_bitcount,
                   prev_out, prev_last, prev_idx);
        end
      end
      if (prev_boundary) begin
        checks++;
        if (sif.serial_valid !== 1'b0 || sif.block_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s_boundary_gap: vld=%b rdy=%b required 0 and 1", name, sif.serial_valid, sif.block_ready);
        end
      end
      if (sif.serial_valid === 1'b1) begin
        checks++;
        if (rx >= exp_q.size()) begin
          errors++; $display("FAIL %s_extra_bit: bit %0d emitted, only %0d supplied", name, rx, exp_q.size());
        end else if (sif.serial_out !== exp_q[rx] || sif.serial_last !== (rx == len - 1) ||
                     debug_bitcount !== 11'(rx % RATE) || debug_state !== 3'd2) begin
          errors++;
          $display("FAIL %s_bit%0d: out=%b last=%b idx=%0d st=%0d required %b %b %0d 2",
                   name, rx, sif.serial_out, sif.serial_last, debug_bitcount, debug_state,
                   exp_q[rx], (rx == len - 1), rx % RATE);
        end
      end
      sif.block_valid = 1'b0;
      if (sif.block_ready === 1'b1 && $urandom_range(0, 99) < block_pct) begin
        blk = rand_block();
        sif.block_in = blk; sif.block_valid = 1'b1;
        for (int i = 0; i < RATE; i++) exp_q.push_back(blk[i]);
        blocks++;
      end
      if (sif.serial_valid === 1'b1 && rx == stall_at && !stall_done) begin
        stall_done = 1; stall_left = 5;
      end
      if (stall_left > 0) begin
        sif.serial_ready = 1'b0; stall_left--;
      end else begin
        sif.serial_ready = ($urandom_range(0, 99) < ready_pct);
      end
      start   = (sif.serial_valid === 1'b1 && rx == start_at);
      out_len = LEN_W'($urandom_range(0, 40));
      prev_stall = (sif.serial_valid === 1'b1) && !sif.serial_ready;
      prev_out = sif.serial_out; prev_last = sif.serial_last; prev_idx = debug_bitcount;
      prev_boundary = 0;
      if (sif.serial_valid === 1'b1 && sif.serial_ready) begin
        rx++;
        prev_boundary = (rx % RATE == 0) && (rx < len);
      end
      @(negedge clk);
    end
    start = 1'b0; sif.block_valid = 1'b0; sif.serial_ready = 1'b0;
    checks++;
    if (rx != len) begin
      errors++; $display("FAIL %s_timeout: received %0d bits required %0d", name, rx, len);
    end
    checks++;
    if (squeeze_done !== 1'b1 || sif.serial_valid !== 1'b0 || sif.block_ready !== 1'b0 || error_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b vld=%b rdy=%b err=%b required 1 0 0 0",
               name, squeeze_done, sif.serial_valid, sif.block_ready, error_flag);
    end
    checks++;
    if (blocks != (len + RATE - 1) / RATE) begin
      errors++; $display("FAIL %s_block_count: %0d blocks required %0d", name, blocks, (len + RATE - 1) / RATE);
    end
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    start = 1'b1; out_len = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (error_flag !== 1'b1 || squeeze_done !== 1'b1 || sif.serial_valid !== 1'b0 ||
          sif.block_ready !== 1'b0 || debug_state !== 3'd3) begin
        errors++;
        $display("FAIL zero_len: err=%b done=%b vld=%b rdy=%b st=%0d required 1 1 0 0 3",
                 error_flag, squeeze_done, sif.serial_valid, sif.block_ready, debug_state);
      end
      @(negedge clk);
    end
    run_squeeze("after_zero", 4, 100, 100, -1, -1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; out_len = LEN_W'(50);
    @(negedge clk);
    start = 1'b0;
    sif.block_in = rand_block(); sif.block_valid = 1'b1; sif.serial_ready = 1'b1;
    @(negedge clk);
    sif.block_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sif.serial_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: serial_valid %b required 1", sif.serial_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sif.serial_valid !== 1'b0 || debug_state !== 3'd0 || sif.serial_last !== 1'b0 ||
        sif.serial_out !== 1'b0 || debug_bitcount !== 11'd0 || squeeze_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: vld=%b st=%0d last=%b out=%b idx=%0d done=%b required all 0",
               sif.serial_valid, debug_state, sif.serial_last, sif.serial_out, debug_bitcount, squeeze_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sif.serial_valid !== 1'b0 || debug_state !== 3'd0 || sif.block_ready !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after: vld=%b st=%0d rdy=%b required 0 0 0",
                 sif.serial_valid, debug_state, sif.block_ready);
      end
    end
    sif.serial_ready = 1'b0;
  endtask

  initial begin
    int len;
    test_reset();
    test_a5();
    run_squeeze("long", RATE + 4, 100, 100, -1, -1);
    run_squeeze("stall", 40, 100, 100, 17, -1);
    run_squeeze("start_ignored", 30, 70, 100, -1, 9);
    test_zero_len();
    test_reset_mid();
    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(1, 2 * RATE + 60);
      run_squeeze("random", len, 60, 50, $urandom_range(0, len - 1), $urandom_range(0, len - 1));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
